// File: rtl/refill_bus_pkg.sv
// Shared definitions for the refill-bus responders: FSM states, line geometry
// and the tagged beat stored in the response buffer.
package refill_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } refill_state_t;

    localparam int DEFAULT_LINE_OFFSET_WIDTH = 5;
    localparam int BEATS = 1 << (DEFAULT_LINE_OFFSET_WIDTH - 2);

    // Words per line for a given byte-offset width.
    function automatic int beats_for(input int line_offset_width);
        return 1 << (line_offset_width - 2);
    endfunction

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_tag_t;

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO used as the response buffer of the refill responders.
// Head is combinational from storage; a push together with a pop while full is accepted.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Data storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_refill_responder.sv
// Memory-side read responder for the instruction-cache refill bus.
// Cached requests return a whole line, uncached requests a single word.
// Optional build macro CRITICAL_WORD_FIRST_EN starts cached bursts at the requested word.
module line_refill_responder
    import refill_bus_pkg::*;
#(
    parameter int LINE_OFFSET_WIDTH = 5,
    parameter int MEM_AW            = 12,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    input  logic              s_cached,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    output logic              s_rlast,
    input  logic              s_rready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int OW         = LINE_OFFSET_WIDTH - 2;
    localparam int LINE_BEATS = beats_for(LINE_OFFSET_WIDTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    refill_state_t     state;
    refill_state_t     state_next;
    logic              arready_q;
    logic [MEM_AW-1:0] base_q;
    logic              cached_q;
    logic [OW-1:0]     start_q;
    logic [OW-1:0]     issue_idx;
    logic [OW-1:0]     offset;
    logic [OW-1:0]     start_sel;
    logic              in_flight;
    logic              in_flight_last;
    logic              handshake;
    logic              issue;
    logic              issue_last;
    logic              credit_ok;
    logic              pop;
    logic              last_pop;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    beat_tag_t         head;
    beat_tag_t         push_tag;
    logic              unused_bits;

    assign handshake  = (state == IDLE) && arready_q && s_arvalid;
    assign pop        = !fifo_empty && s_rready;
    assign last_pop   = pop && head.last;
    assign offset     = start_q + issue_idx;
    assign issue_last = !cached_q || (issue_idx == OW'(LINE_BEATS - 1));
    assign credit_ok  = (int'(fifo_count) + int'(in_flight) - int'(pop)) < FIFO_DEPTH;
    assign mem_addr   = cached_q ? {base_q[MEM_AW-1:OW], offset} : base_q;
    assign mem_en     = issue;
    assign push_tag   = '{last: in_flight_last, data: mem_rdata};

    assign s_arready  = arready_q;
    assign s_rvalid   = !fifo_empty;
    assign s_rdata    = fifo_empty ? 32'd0 : head.data;
    assign s_rlast    = !fifo_empty && head.last;

    assign unused_bits = ^{s_araddr[31:MEM_AW+2], s_araddr[1:0], fifo_full};

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_sel = s_cached ? s_araddr[LINE_OFFSET_WIDTH-1:2] : '0;
`else
    assign start_sel = '0;
`endif

    // Next-state and memory issue decisions.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers; s_arready is registered so it rises one cycle after reset or the last pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            arready_q      <= 1'b0;
            base_q         <= '0;
            cached_q       <= 1'b0;
            start_q        <= '0;
            issue_idx      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_next;
            arready_q      <= (state_next == IDLE);
            in_flight      <= issue;
            in_flight_last <= issue && issue_last;
            if (handshake) begin
                base_q    <= s_araddr[MEM_AW+1:2];
                cached_q  <= s_cached;
                start_q   <= start_sel;
                issue_idx <= '0;
            end else if (issue) begin
                issue_idx <= issue_idx + 1'b1;
            end
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_tag_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data (push_tag),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_line_refill_responder.sv
// Testbench for line_refill_responder: BRAM model, randomized traffic and a
// line-level reference model of the expected beat sequence.
module tb_line_refill_responder;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_cached;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        s_rlast;
    logic        s_rready;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem_arr [4096];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          errors;
    int          checks;

    line_refill_responder #(
        .LINE_OFFSET_WIDTH (5),
        .MEM_AW            (12),
        .FIFO_DEPTH        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_cached  (s_cached),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .s_rready  (s_rready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency synchronous-read memory.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_arr[mem_addr];
    end

    // Reference model: the list of beats a request must produce.
    task automatic model_request(input logic [31:0] addr, input logic cached);
        int w, line, start, wd;
        w = int'((addr >> 2) % 4096);
        if (cached) begin
            line = w - (w % 8);
`ifdef CRITICAL_WORD_FIRST_EN
            start = w % 8;
`else
            start = 0;
`endif
            for (int k = 0; k < 8; k++) begin
                wd = line + ((start + k) % 8);
                exp_q.push_back('{data: 32'hA000_0000 | (wd << 2), last: (k == 7)});
            end
        end else begin
            exp_q.push_back('{data: 32'hA000_0000 | (w << 2), last: 1'b1});
        end
    endtask

    // Issue one request and collect its beats; mode 0 = rready high, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic do_burst(input logic [31:0] addr, input logic cached, input int mode,
                            input int stop_after, output int latency, output int stall_bad,
                            output int max_cnt, output int timed_out);
        int   c, pops;
        logic done, prev_stall, prev_last;
        logic [31:0] prev_data;
        got_q.delete();
        latency = -1; stall_bad = 0; max_cnt = 0; timed_out = 0;
        pops = 0; done = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        @(posedge clk); #1;
        s_araddr = addr; s_cached = cached; s_arvalid = 1'b1;
        c = 0;
        forever begin
            @(negedge clk);
            if (s_arready) break;
            c++;
            if (c > 50) begin timed_out = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0; s_araddr = $urandom; s_cached = 1'($urandom);
        if (timed_out != 0) return;
        c = 0;
        while (!done) begin
            case (mode)
                0:       s_rready = 1'b1;
                1:       s_rready = (c % 4 == 0) || (c % 4 == 3);
                default: s_rready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            c++;
            if (s_rvalid && latency < 0) latency = c;
            if (prev_stall && (!s_rvalid || s_rdata !== prev_data || s_rlast !== prev_last))
                stall_bad++;
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (s_rvalid && s_rready) begin
                got_q.push_back('{data: s_rdata, last: s_rlast});
                pops++;
                if (s_rlast || (stop_after != 0 && pops == stop_after)) done = 1;
            end
            prev_stall = s_rvalid && !s_rready;
            prev_data  = s_rdata;
            prev_last  = s_rlast;
            if (c > 200) begin timed_out = 1; done = 1; end
            if (!done) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; s_arvalid = 0; s_araddr = '0; s_cached = 0; s_rready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_arready !== 1'b0) begin errors++; $display("[TB] FAIL reset_arready: got %b expected 0", s_arready); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", s_rvalid); end
        checks++; if (s_rlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_rlast: got %b expected 0", s_rlast); end
        checks++; if (s_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", s_rdata); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (s_arready !== 1'b0) begin errors++; $display("[TB] FAIL arready_first_cycle: got %b expected 0", s_arready); end
        @(negedge clk);
        checks++; if (s_arready !== 1'b1) begin errors++; $display("[TB] FAIL arready_second_cycle: got %b expected 1", s_arready); end
    endtask

    task automatic test_cached_line;
        int lat, sb, mc, to;
        exp_q.delete(); model_request(32'h0000_0044, 1'b1);
        do_burst(32'h0000_0044, 1'b1, 0, 0, lat, sb, mc, to);
        checks++; if (to !== 0) begin errors++; $display("[TB] FAIL cached_timeout: got %0d expected 0", to); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL cached_latency: got %0d expected 3", lat); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL cached_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++; $display("[TB] FAIL cached_beat%0d: got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_uncached;
        int lat, sb, mc, to;
        exp_q.delete(); model_request(32'h0000_0108, 1'b0);
        do_burst(32'h0000_0108, 1'b0, 0, 0, lat, sb, mc, to);
        checks++; if (to !== 0) begin errors++; $display("[TB] FAIL uncached_timeout: got %0d expected 0", to); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL uncached_latency: got %0d expected 3", lat); end
        checks++; if (s_arready !== 1'b0) begin errors++; $display("[TB] FAIL uncached_arready_at_pop: got %b expected 0", s_arready); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL uncached_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++; $display("[TB] FAIL uncached_beat%0d: got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        @(negedge clk);
        checks++; if (s_arready !== 1'b1) begin errors++; $display("[TB] FAIL uncached_arready_after_pop: got %b expected 1", s_arready); end
    endtask

    task automatic test_backpressure;
        int lat, sb, mc, to;
        exp_q.delete(); model_request(32'h0000_0234, 1'b1);
        do_burst(32'h0000_0234, 1'b1, 1, 0, lat, sb, mc, to);
        checks++; if (to !== 0) begin errors++; $display("[TB] FAIL bp_timeout: got %0d expected 0", to); end
        checks++; if (sb !== 0) begin errors++; $display("[TB] FAIL bp_stall_stable: got %0d unstable cycles expected 0", sb); end
        checks++; if (mc > 2) begin errors++; $display("[TB] FAIL bp_fifo_count: got %0d expected at most 2", mc); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++; $display("[TB] FAIL bp_beat%0d: got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        int lat, sb, mc, to, stale;
        do_burst(32'h0000_0388, 1'b1, 0, 3, lat, sb, mc, to);
        checks++; if (got_q.size() !== 3) begin errors++; $display("[TB] FAIL midrst_prefix: got %0d beats expected 3", got_q.size()); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rvalid: got %b expected 0", s_rvalid); end
        checks++; if (s_arready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_arready: got %b expected 0", s_arready); end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_rvalid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL midrst_stale: got %0d valid cycles expected 0", stale); end
        exp_q.delete(); model_request(32'h0000_0000, 1'b1);
        do_burst(32'h0000_0000, 1'b1, 0, 0, lat, sb, mc, to);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL midrst_new_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++; $display("[TB] FAIL midrst_beat%0d: got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_back_to_back;
        int c, hs, hs2_c, last_pop_c;
        exp_q.delete(); model_request(32'h0000_0560, 1'b1); model_request(32'h0000_07A4, 1'b1);
        got_q.delete();
        @(posedge clk); #1;
        s_araddr = 32'h0000_0560; s_cached = 1'b1; s_arvalid = 1'b1; s_rready = 1'b1;
        c = 0; hs = 0; hs2_c = -1; last_pop_c = -1;
        while (c < 300) begin
            @(negedge clk);
            c++;
            if (s_arvalid && s_arready) begin hs++; if (hs == 2) hs2_c = c; end
            if (s_rvalid && s_rready) begin
                got_q.push_back('{data: s_rdata, last: s_rlast});
                if (s_rlast && last_pop_c < 0) last_pop_c = c;
            end
            if (got_q.size() >= 16) break;
            @(posedge clk); #1;
            if (hs == 1) s_araddr = 32'h0000_07A4;
            if (hs >= 2) s_arvalid = 1'b0;
        end
        s_arvalid = 1'b0;
        checks++; if (hs !== 2) begin errors++; $display("[TB] FAIL b2b_handshakes: got %0d expected 2", hs); end
        checks++; if (hs2_c !== last_pop_c + 1) begin errors++; $display("[TB] FAIL b2b_second_hs: got cycle %0d expected %0d", hs2_c, last_pop_c + 1); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                errors++; $display("[TB] FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random;
        int lat, sb, mc, to;
        logic [31:0] addr;
        logic        cached;
        for (int t = 0; t < 8; t++) begin
            addr = $urandom;
            cached = 1'($urandom_range(0, 1));
            exp_q.delete(); model_request(addr, cached);
            do_burst(addr, cached, 2, 0, lat, sb, mc, to);
            checks++; if (to !== 0) begin errors++; $display("[TB] FAIL rand%0d_timeout: got %0d expected 0", t, to); end
            checks++; if (sb !== 0) begin errors++; $display("[TB] FAIL rand%0d_stall_stable: got %0d expected 0", t, sb); end
            checks++; if (mc > 2) begin errors++; $display("[TB] FAIL rand%0d_fifo_count: got %0d expected at most 2", t, mc); end
            checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", t, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                    errors++; $display("[TB] FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", t, i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hA000_0000 | (i << 2);
        test_reset();
        test_cached_line();
        test_uncached();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_refill_responder.md
Name: line_refill_responder

Overview:
- Memory-side read responder for the instruction-cache refill bus.
- Accepts one read request per transaction (araddr/arvalid/arready) and returns data beats (rdata/rvalid/rlast/rready).
- A cached request returns a full line of 2^(LINE_OFFSET_WIDTH-2) words; an uncached request returns a single word.
- Sits between the cache's miss path and a synchronous-read, one-cycle-latency word memory (BRAM).

Parameters:
- LINE_OFFSET_WIDTH, 5, byte-offset bits per line (5 gives 8 words per line).
- MEM_AW, 12, word-address width of the backing memory.
- FIFO_DEPTH, 2, entries in the response buffer (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_araddr  in  32  request byte address.
- s_arvalid  in  1  request valid.
- s_cached  in  1  1 = line burst, 0 = single word; sampled at the address handshake.
- s_arready  out  1  request accepted when s_arvalid&&s_arready.
- s_rdata  out  32  beat data.
- s_rvalid  out  1  beat valid.
- s_rlast  out  1  final beat of the transaction.
- s_rready  in  1  consumer accepts the beat.
- mem_en  out  1  memory read strobe.
- mem_addr  out  MEM_AW  memory word address.
- mem_rdata  in  32  memory data, valid on the cycle after mem_en.

Behaviour:
- Reset: all outputs are 0; the FSM enters IDLE, the FIFO is emptied and all counters are cleared. s_arready rises 1 cycle after rst deasserts.
- Reset mid-burst aborts the transaction:
  - in-flight memory data is discarded;
  - no further beats are produced;
  - s_rvalid drops on the cycle after rst is sampled.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - s_arready=1.
  - On handshake, latch the base address and beat count, deassert s_arready and go to BURST.
  - Base word is s_araddr[MEM_AW+1:2]. If cached, the low LINE_OFFSET_WIDTH-2 bits are cleared and beats = 2^(LINE_OFFSET_WIDTH-2); otherwise beats = 1.
- BURST:
  - Issue mem_en with mem_addr = base | offset when credit allows; offset increments per issue.
  - Credit rule: issue only when (fifo_count + in_flight - pop_this_cycle) < FIFO_DEPTH.
  - After the last issue, go to DRAIN.
- DRAIN:
  - Wait until the last beat is popped (s_rvalid&&s_rready&&s_rlast), then go to IDLE.
  - s_arready is asserted on the cycle after that pop.
- Memory return: mem_rdata is captured into the FIFO on the cycle after mem_en. The FIFO head drives s_rdata and s_rvalid.
- s_rlast: driven from a per-entry tag that is set on the final issued beat.
- Handshake rules:
  - While s_rvalid is high and s_rready is low, s_rdata and s_rlast hold stable.
  - s_rvalid is never withdrawn before acceptance.
- Latency with s_rready held high:
  - first s_rvalid is 3 cycles after the address-handshake edge;
  - then 1 beat per cycle, no bubbles.
- Back-to-back transactions: the next request is accepted 1 cycle after the last-beat pop.
- Offset arithmetic: modulo beats, so the offset wraps within the line. mem_addr upper bits come from the base address.
- Address bits above MEM_AW+1 are ignored (aliasing).
- Simultaneous FIFO push and pop while full is legal and occupancy is unchanged. Push into a full FIFO is impossible by the credit rule; the verifier asserts this.
- An s_arvalid arriving outside IDLE is held off by s_arready=0 and is never dropped.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- With the macro defined: a cached burst starts at the requested word (offset = s_araddr[LINE_OFFSET_WIDTH-1:2]) and wraps modulo beats. s_rlast is on the 8th beat regardless of start offset.
- Without the macro: cached bursts always start at offset 0.
- Uncached behaviour is identical in both builds.

Decomposition:
- Shared package refill_bus_pkg holds:
  - state encoding (IDLE, BURST, DRAIN);
  - localparam BEATS = 1 << (LINE_OFFSET_WIDTH-2);
  - the beat-tag struct {last, data}.
- One sub-module, resp_fifo: synchronous FIFO of depth FIFO_DEPTH with push, pop, count, head and full/empty flags. It is reused by a later data-cache responder.

Test Plan:
- Memory is preloaded so that mem[i] = 32'hA000_0000 | (i<<2).
- Cached read at 0x0000_0044, s_rready=1:
  - 8 beats 0xA000_0040 through 0xA000_005C;
  - s_rlast only on 0xA000_005C;
  - first s_rvalid 3 cycles after the handshake.
- With CRITICAL_WORD_FIRST_EN, same request:
  - beats 0xA000_0044 through 0xA000_005C, then 0xA000_0040;
  - s_rlast on 0xA000_0040.
- Uncached read at 0x0000_0108, s_cached=0: exactly one beat 0xA000_0108 with s_rlast=1; s_arready returns 1 cycle after the pop.
- Cached burst with s_rready toggling 1,0,0,1 repeating:
  - all 8 beats arrive in order, none duplicated or lost;
  - s_rdata is stable while stalled;
  - FIFO count never exceeds 2.
- rst asserted for 1 cycle after the 3rd beat:
  - s_rvalid=0 on the next cycle;
  - no stale beats afterward;
  - a new cached request at 0x0000_0000 then returns 0xA000_0000 through 0xA000_001C.
- Two cached requests with s_arvalid held high continuously: the second handshake occurs only after the first s_rlast pop, and both bursts are complete.
